// File: rtl/shift_ctrl_4_pkg.sv
// Shared definitions for the shift-register sequencer: register mode encodings,
// FSM state encoding and the direction-to-mode mapping.
package shift_ctrl_4_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SR   = 2'b01;
    localparam logic [1:0] MODE_SL   = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // dir=0 shifts right (LSB leaves first), dir=1 shifts left (MSB leaves first).
    function automatic logic [1:0] shift_mode(input logic dir);
        return dir ? MODE_SL : MODE_SR;
    endfunction

endpackage

// File: rtl/shift_tx_4_top.sv
// Parallel-to-serial transmitter: sequencer plus universal shift register,
// with the register's active-low clear driven from the active-high clear.
module shift_tx_4_top
    import shift_ctrl_4_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SHIFT_COUNT = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             dir,
    input  logic             rotate,
    input  logic             fill_bit,
    input  logic             abort,
    output logic [WIDTH-1:0] a_par,
    output logic             ready,
    output logic             tx_bit,
    output logic             tx_valid,
    output logic             done
);

    logic             w_s1;
    logic             w_s0;
    logic [WIDTH-1:0] w_i_par;
    logic             w_msb_in;
    logic             w_lsb_in;
    logic             w_clr_n;
    logic [WIDTH-1:0] w_a_par;

    assign w_clr_n = ~clear;
    assign a_par   = w_a_par;

    shift_ctrl_4_beh #(
        .WIDTH       (WIDTH),
        .SHIFT_COUNT (SHIFT_COUNT)
    ) u_ctrl (
        .clk      (clk),
        .clear    (clear),
        .start    (start),
        .din      (din),
        .dir      (dir),
        .rotate   (rotate),
        .fill_bit (fill_bit),
        .abort    (abort),
        .a_par    (w_a_par),
        .s1       (w_s1),
        .s0       (w_s0),
        .i_par    (w_i_par),
        .msb_in   (w_msb_in),
        .lsb_in   (w_lsb_in),
        .ready    (ready),
        .tx_bit   (tx_bit),
        .tx_valid (tx_valid),
        .done     (done)
    );

    shift_ureg_4 #(
        .WIDTH (WIDTH)
    ) u_reg (
        .clk      (clk),
        .i_clr_n  (w_clr_n),
        .i_s1     (w_s1),
        .i_s0     (w_s0),
        .i_par    (w_i_par),
        .i_msb_in (w_msb_in),
        .i_lsb_in (w_lsb_in),
        .o_q      (w_a_par)
    );

endmodule

// File: rtl/shift_ureg_4.sv
// Universal shift register with 74194-style mode selects:
// hold, shift right, shift left and parallel load, plus an async active-low clear.
module shift_ureg_4
    import shift_ctrl_4_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             i_clr_n,
    input  logic             i_s1,
    input  logic             i_s0,
    input  logic [WIDTH-1:0] i_par,
    input  logic             i_msb_in,
    input  logic             i_lsb_in,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_q <= '0;
        end else begin
            case ({i_s1, i_s0})
                MODE_SR:   r_q <= {i_msb_in, r_q[WIDTH-1:1]};
                MODE_SL:   r_q <= {r_q[WIDTH-2:0], i_lsb_in};
                MODE_LOAD: r_q <= i_par;
                default:   r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/shift_ctrl_4_beh.sv
// Sequencer for the universal shift register: accepts a nibble, loads it, then
// shifts it out SHIFT_COUNT times while presenting each leaving bit as tx_bit/tx_valid.
module shift_ctrl_4_beh
    import shift_ctrl_4_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SHIFT_COUNT = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             dir,
    input  logic             rotate,
    input  logic             fill_bit,
    input  logic             abort,
    input  logic [WIDTH-1:0] a_par,
    output logic             s1,
    output logic             s0,
    output logic [WIDTH-1:0] i_par,
    output logic             msb_in,
    output logic             lsb_in,
    output logic             ready,
    output logic             tx_bit,
    output logic             tx_valid,
    output logic             done
);

    localparam int             CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST = CW'(SHIFT_COUNT - 1);

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic             r_dir;
    logic             r_rotate;
    logic [1:0]       r_mode;
    logic [WIDTH-1:0] r_i_par;
    logic             r_ready;
    logic             r_tx_valid;
    logic             r_done;

    logic             w_shift;
    logic             w_unused_par;

    // NOTE: every output register is written together with the state it belongs
    // to, using non-blocking assignments, so outputs always match r_state.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_dir      <= 1'b0;
            r_rotate   <= 1'b0;
            r_mode     <= MODE_HOLD;
            r_i_par    <= '0;
            r_ready    <= 1'b1;
            r_tx_valid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state  <= ST_LOAD;
                        r_i_par  <= din;
                        r_dir    <= dir;
                        r_rotate <= rotate;
                        r_mode   <= MODE_LOAD;
                        r_ready  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    r_i_par <= '0;
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_mode  <= MODE_HOLD;
                        r_ready <= 1'b1;
                    end else begin
                        r_state    <= ST_SHIFT;
                        r_count    <= '0;
                        r_mode     <= shift_mode(r_dir);
                        r_tx_valid <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    r_count <= r_count + 1'b1;
                    // The shift at this edge happens regardless; abort only skips DONE.
                    if (abort) begin
                        r_state    <= ST_IDLE;
                        r_mode     <= MODE_HOLD;
                        r_tx_valid <= 1'b0;
                        r_ready    <= 1'b1;
                    end else if (r_count == LAST) begin
                        r_state    <= ST_DONE;
                        r_mode     <= MODE_HOLD;
                        r_tx_valid <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_shift = (r_state == ST_SHIFT);

    assign s1       = r_mode[1];
    assign s0       = r_mode[0];
    assign i_par    = r_i_par;
    assign ready    = r_ready;
    assign tx_valid = r_tx_valid;
    assign done     = r_done;

    assign tx_bit = r_dir ? a_par[WIDTH-1] : a_par[0];
    assign msb_in = (w_shift && !r_dir) ? (r_rotate ? a_par[0]       : fill_bit) : 1'b0;
    assign lsb_in = (w_shift &&  r_dir) ? (r_rotate ? a_par[WIDTH-1] : fill_bit) : 1'b0;

    // Only the end bits of the register feed back; the middle bits are observed, not used.
    assign w_unused_par = ^a_par;

endmodule

// File: tb/tb_shift_ctrl_4_beh.sv
// Scoreboard bench: sequencer+register with SHIFT_COUNT=4 and the integrated
// transmitter with SHIFT_COUNT=2, checked against an arithmetic transfer model.
module tb_shift_ctrl_4_beh;

    logic       clk = 1'b0;
    logic       clear;
    logic       start_r;
    logic       abort_r;
    logic       sel_r;
    logic [3:0] din;
    logic       dir;
    logic       rotate;
    logic       fill_bit;

    logic       w_start1, w_start2, w_abort1, w_abort2, clr_n;
    logic       s1, s0, msb_in, lsb_in, ready1, tx_bit1, tx_valid1, done1;
    logic [3:0] i_par, a_par1;
    logic       ready2, tx_bit2, tx_valid2, done2;
    logic [3:0] a_par2;

    int total = 0;
    int bad   = 0;

    bit         q_bits1[$];
    bit         q_bits2[$];
    logic [3:0] q_fin1[$];
    logic [3:0] q_fin2[$];
    logic       prev_done1 = 1'b0;
    logic       prev_done2 = 1'b0;

    always #5 clk = ~clk;

    assign w_start1 = start_r & ~sel_r;
    assign w_start2 = start_r &  sel_r;
    assign w_abort1 = abort_r & ~sel_r;
    assign w_abort2 = abort_r &  sel_r;
    assign clr_n    = ~clear;

    shift_ctrl_4_beh #(.WIDTH(4), .SHIFT_COUNT(4)) u_ctrl (
        .clk(clk), .clear(clear), .start(w_start1), .din(din), .dir(dir),
        .rotate(rotate), .fill_bit(fill_bit), .abort(w_abort1), .a_par(a_par1),
        .s1(s1), .s0(s0), .i_par(i_par), .msb_in(msb_in), .lsb_in(lsb_in),
        .ready(ready1), .tx_bit(tx_bit1), .tx_valid(tx_valid1), .done(done1)
    );

    shift_ureg_4 #(.WIDTH(4)) u_reg (
        .clk(clk), .i_clr_n(clr_n), .i_s1(s1), .i_s0(s0), .i_par(i_par),
        .i_msb_in(msb_in), .i_lsb_in(lsb_in), .o_q(a_par1)
    );

    shift_tx_4_top #(.WIDTH(4), .SHIFT_COUNT(2)) u_tx2 (
        .clk(clk), .clear(clear), .start(w_start2), .din(din), .dir(dir),
        .rotate(rotate), .fill_bit(fill_bit), .abort(w_abort2), .a_par(a_par2),
        .ready(ready2), .tx_bit(tx_bit2), .tx_valid(tx_valid2), .done(done2)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the k-th bit out is simply the k-th bit of the word in
    // shift order; the final word is a rotate or a fill-padded shift by n.
    function automatic bit model_bit(input logic [3:0] d, input logic dr, input int k);
        return dr ? d[3-k] : d[k];
    endfunction

    function automatic int model_final(input logic [3:0] d, input logic dr, input logic rt,
                                       input logic fl, input int n);
        int v = int'(d);
        int r;
        if (!dr) r = rt ? ((v >> n) | (v << (4 - n))) : ((v >> n) | (fl ? (15 << (4 - n)) : 0));
        else     r = rt ? ((v << n) | (v >> (4 - n))) : ((v << n) | (fl ? ((1 << n) - 1) : 0));
        return r & 15;
    endfunction

    function automatic int f_ready(input int sel);
        return sel != 0 ? int'(ready2) : int'(ready1);
    endfunction

    function automatic int f_apar(input int sel);
        return sel != 0 ? int'(a_par2) : int'(a_par1);
    endfunction

    task automatic push_expect(input int sel, input logic [3:0] d, input logic dr,
                               input logic rt, input logic fl, input int nsh, input bit with_done);
        for (int k = 0; k < nsh; k++) begin
            if (sel != 0) q_bits2.push_back(model_bit(d, dr, k));
            else          q_bits1.push_back(model_bit(d, dr, k));
        end
        if (with_done) begin
            if (sel != 0) q_fin2.push_back(4'(model_final(d, dr, rt, fl, nsh)));
            else          q_fin1.push_back(4'(model_final(d, dr, rt, fl, nsh)));
        end
    endtask

    // Monitors: pop one expected bit per tx_valid cycle, one final word per done pulse.
    always @(negedge clk) begin
        if (clear) begin
            prev_done1 = 1'b0;
        end else begin
            if (tx_valid1) begin
                check("tx1_pending", int'(q_bits1.size() > 0), 1);
                if (q_bits1.size() > 0) check("tx1_bit", int'(tx_bit1), int'(q_bits1.pop_front()));
            end
            if (done1) begin
                check("done1_width", int'(prev_done1), 0);
                check("done1_expected", int'(q_fin1.size() > 0), 1);
                if (q_fin1.size() > 0) check("a_par1_final", int'(a_par1), int'(q_fin1.pop_front()));
            end
            prev_done1 = done1;
        end
    end

    always @(negedge clk) begin
        if (clear) begin
            prev_done2 = 1'b0;
        end else begin
            if (tx_valid2) begin
                check("tx2_pending", int'(q_bits2.size() > 0), 1);
                if (q_bits2.size() > 0) check("tx2_bit", int'(tx_bit2), int'(q_bits2.pop_front()));
            end
            if (done2) begin
                check("done2_width", int'(prev_done2), 0);
                check("done2_expected", int'(q_fin2.size() > 0), 1);
                if (q_fin2.size() > 0) check("a_par2_final", int'(a_par2), int'(q_fin2.pop_front()));
            end
            prev_done2 = done2;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int sel);
        int guard = 0;
        while (f_ready(sel) != 1 && guard < 40) begin
            tick();
            guard++;
        end
        check("ready_wait", f_ready(sel), 1);
    endtask

    // One transfer; abort_at=k asserts abort during the k-th SHIFT cycle.
    task automatic xfer(input int sel, input logic [3:0] d, input logic dr, input logic rt,
                        input logic fl, input int abort_at);
        int n = (sel != 0) ? 2 : 4;
        int nsh = (abort_at > 0) ? abort_at : n;
        sel_r = sel[0];
        wait_ready(sel);
        din = d; dir = dr; rotate = rt; fill_bit = fl;
        push_expect(sel, d, dr, rt, fl, nsh, abort_at == 0);
        start_r = 1'b1;
        tick();
        start_r = 1'b0;
        din = 4'($urandom); dir = 1'($urandom); rotate = 1'($urandom);
        check("load_busy", f_ready(sel), 0);
        if (sel == 0) begin
            check("load_mode", int'({s1, s0}), 3);
            check("load_ipar", int'(i_par), int'(d));
        end
        for (int k = 1; k <= n + 1; k++) begin
            tick();
            if (abort_at == k) begin
                abort_r = 1'b1;
                tick();
                abort_r = 1'b0;
                check("abort_ready", f_ready(sel), 1);
                check("abort_apar", f_apar(sel), model_final(d, dr, rt, fl, nsh));
                return;
            end
            check("xfer_busy", f_ready(sel), 0);
        end
        // Ready rises N+2 edges after the accept edge (accept, LOAD, N SHIFT, DONE cycles).
        tick();
        check("xfer_ready", f_ready(sel), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] d_a, d_b;
        clear = 1'b1; start_r = 1'b0; abort_r = 1'b0; sel_r = 1'b0;
        din = '0; dir = 1'b0; rotate = 1'b0; fill_bit = 1'b0;

        #12;
        check("rst_ready1", int'(ready1), 1);
        check("rst_ready2", int'(ready2), 1);
        check("rst_mode", int'({s1, s0}), 0);
        check("rst_ipar", int'(i_par), 0);
        check("rst_txv", int'(tx_valid1), 0);
        check("rst_done", int'(done1), 0);
        check("rst_fill", int'({msb_in, lsb_in}), 0);
        @(negedge clk);
        clear = 1'b0;

        xfer(0, 4'b1011, 1'b0, 1'b0, 1'b0, 0);
        xfer(0, 4'b1001, 1'b1, 1'b1, 1'b0, 0);
        xfer(1, 4'b0110, 1'b0, 1'b0, 1'b1, 0);
        xfer(0, 4'b1100, 1'b0, 1'b0, 1'b0, 2);
        xfer(0, 4'b0111, 1'b1, 1'b0, 1'b1, 4);

        // start held high: two transfers with exactly one IDLE cycle between them.
        sel_r = 1'b0;
        wait_ready(0);
        d_a = 4'($urandom); d_b = 4'($urandom);
        din = d_a; dir = 1'b1; rotate = 1'b0; fill_bit = 1'b1;
        push_expect(0, d_a, 1'b1, 1'b0, 1'b1, 4, 1'b1);
        start_r = 1'b1;
        tick();
        din = d_b;
        push_expect(0, d_b, 1'b1, 1'b0, 1'b1, 4, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("b2b_busy_a", int'(ready1), 0);
        end
        tick();
        check("b2b_idle", int'(ready1), 1);
        tick();
        check("b2b_accept_b", int'(ready1), 0);
        start_r = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("b2b_busy_b", int'(ready1), 0);
        end
        tick();
        check("b2b_ready", int'(ready1), 1);

        // Asynchronous clear in the middle of SHIFT.
        wait_ready(0);
        din = 4'b1010; dir = 1'b0; rotate = 1'b0; fill_bit = 1'b0;
        push_expect(0, 4'b1010, 1'b0, 1'b0, 1'b0, 4, 1'b1);
        start_r = 1'b1;
        tick();
        start_r = 1'b0;
        tick();
        tick();
        #2 clear = 1'b1;
        #1;
        check("clr_ready", int'(ready1), 1);
        check("clr_mode", int'({s1, s0}), 0);
        check("clr_txv", int'(tx_valid1), 0);
        check("clr_done", int'(done1), 0);
        check("clr_fill", int'({msb_in, lsb_in}), 0);
        check("clr_apar", int'(a_par1), 0);
        q_bits1.delete();
        q_fin1.delete();
        @(negedge clk);
        #1 clear = 1'b0;

        for (int i = 0; i < 14; i++) begin
            int sel = int'($urandom_range(0, 1));
            int n = (sel != 0) ? 2 : 4;
            int ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, n)) : 0;
            xfer(sel, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), ab);
        end

        repeat (4) tick();
        check("left_bits1", q_bits1.size(), 0);
        check("left_bits2", q_bits2.size(), 0);
        check("left_fin1", q_fin1.size(), 0);
        check("left_fin2", q_fin2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_ctrl_4_beh.md
Name: shift_ctrl_4_beh

Overview:
Sequencer directly upstream of the 4-bit universal shift register. Accepts a parallel nibble over a valid/ready handshake and drives the register's mode selects, parallel-load data and serial fill inputs: one load cycle, then N shift cycles. It monitors the register's parallel output and presents each outgoing bit as a serial stream with a strobe, giving a complete parallel-to-serial transmitter with zero-fill or rotate modes.

Parameters:
WIDTH, 4, data width; must equal the attached register width.
SHIFT_COUNT, 4, shifts per transfer; legal range 1..WIDTH.

Ports:
clk  input  1  rising-edge clock, shared with the shift register.
clear  input  1  asynchronous, active-high reset. The register's active-low clear is driven through an inverter at integration.
start  input  1  request; accepted when start=1 and ready=1.
din  input  WIDTH  data word, sampled on the accept edge.
dir  input  1  sampled on accept; 0 = shift right (LSB first), 1 = shift left (MSB first).
rotate  input  1  sampled on accept; 1 = recirculate the outgoing bit, 0 = use fill_bit.
fill_bit  input  1  serial fill value when rotate=0, used live.
abort  input  1  terminates the transfer in progress.
a_par  input  WIDTH  register parallel output (feedback).
s1, s0  output  1 each  register mode: 00 hold, 01 right, 10 left, 11 load.
i_par  output  WIDTH  register parallel-load data.
msb_in  output  1  serial input for right shift.
lsb_in  output  1  serial input for left shift.
ready  output  1  high only in IDLE.
tx_bit  output  1  outgoing serial bit.
tx_valid  output  1  tx_bit qualifier.
done  output  1  one-cycle completion pulse.

Behaviour:
- FSM states: IDLE, LOAD, SHIFT, DONE. All outputs are a Moore decode of state and registers. The only exceptions are tx_bit, msb_in and lsb_in, which are combinational from a_par, the latched dir/rotate, and fill_bit.
- Reset (clear=1, asynchronous): state=IDLE, data/dir/rotate latches=0, count=0. Outputs: s1s0=00, i_par=0, ready=1, tx_valid=0, done=0. msb_in and lsb_in are forced to 0 outside SHIFT.
- IDLE: ready=1, s1s0=00. On a clk edge with start=1, latch din, dir and rotate, then go to LOAD. start=0 stays in IDLE.
- LOAD (1 cycle): s1s0=11, i_par=latched data. At the next edge the register loads; go to SHIFT with count=0.
- SHIFT: s1s0=01 if dir=0, else 10. tx_valid=1.
  - tx_bit = a_par[0] when dir=0, a_par[WIDTH-1] when dir=1. This is the bit leaving at the coming edge.
  - Fill, dir=0: msb_in = rotate ? a_par[0] : fill_bit, and lsb_in=0.
  - Fill, dir=1: lsb_in = rotate ? a_par[WIDTH-1] : fill_bit, and msb_in=0.
  - Each edge increments count. When count==SHIFT_COUNT-1 at an edge, go to DONE.
- DONE (1 cycle): done=1, s1s0=00, tx_valid=0, then go to IDLE.
- Latency: accept edge to first tx_valid = 2 cycles. One transfer occupies 1+1+SHIFT_COUNT+1 cycles from the accept edge back to ready.
- start while not ready is ignored, with no queueing. din changes after accept have no effect.
- abort=1 in LOAD or SHIFT: go to IDLE at the next edge. done is not pulsed, and the register holds its partial contents. If abort and the final shift coincide, abort wins: the shift edge still happens (mode is already driven), but there is no DONE.
- abort in IDLE or DONE has no effect.
- clear mid-transfer returns to IDLE immediately (asynchronous), and outputs take reset values.
- count width is clog2(WIDTH)+1. It never wraps within a transfer.

Decomposition:
- Shared package/include holds:
  - mode constants MODE_HOLD=2'b00, MODE_SR=2'b01, MODE_SL=2'b10, MODE_LOAD=2'b11;
  - state encodings.
- One natural sub-module: shift_tx_4_top, which instantiates shift_ctrl_4_beh plus the shift register with the clear inversion. The bench runs against it.

Test Plan:
- Reset: clear=1 mid-SHIFT -> next sample shows ready=1, s1s0=00, tx_valid=0, done=0.
- dir=0, rotate=0, fill_bit=0, din=4'b1011 -> tx_bit sequence 1,1,0,1 on tx_valid; a_par=0000 after DONE; done high exactly one cycle.
- dir=1, rotate=1, din=4'b1001 -> tx_bit 1,0,0,1; a_par returns to 1001 after DONE.
- SHIFT_COUNT=2, dir=0, fill_bit=1, din=4'b0110 -> tx_bit 0,1; final a_par=1101; ready returns 5 cycles after the accept edge.
- abort on 2nd SHIFT cycle, din=4'b1100, dir=0, fill 0 -> no done pulse; a_par=0011 held; ready=1 the next cycle.
- start held high continuously -> back-to-back transfers separated by exactly one IDLE cycle; start during SHIFT ignored (din changes have no effect).
